// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param.
//   master : the receiver; drives rx_data, rx_valid, parity_err, frame_err and
//            overrun, and samples rx_ready.
//   slave  : the consumer (FIFO, command decoder); drives rx_ready and samples
//            everything else.
// rx_data/parity_err/frame_err are meaningful only while rx_valid=1.
// overrun is a one-cycle pulse.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampled serial receiver. clk is the oversample tick:
// OVERSAMPLE clk cycles make one bit period.
//   clk     : oversample clock, rising edge
//   rst_n   : synchronous active-low reset
//   data_in : asynchronous serial line, idle high
//   busy    : high whenever the receiver is not in IDLE
//   rx      : handshake bundle (rx_data, rx_valid, rx_ready, parity_err,
//             frame_err, overrun)
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stops.
// Each bit is a 3-sample majority vote ending at the bit centre.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  output logic             busy,
  uart_rx_param_if.master  rx
);

  localparam int              CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   HALF_M1   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1   = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic            PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchroniser (sync_p0 -> rx_s) followed by two history taps for the
  // vote. The vld_pN chain marks which taps hold real line samples rather
  // than reset values, so a line held low through reset is never seen as a
  // falling edge.
  logic sync_p0, rx_s, rx_h1, rx_h2;
  logic vld_p0, vld_p1, vld_h1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      rx_s    <= 1'b1;
      rx_h1   <= 1'b1;
      rx_h2   <= 1'b1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_h1  <= 1'b0;
    end else begin
      sync_p0 <= data_in;
      rx_s    <= sync_p0;
      rx_h1   <= rx_s;
      rx_h2   <= rx_h1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_h1  <= vld_p1;
    end
  end

  logic vote, fall;
  assign vote = majority3(rx_s, rx_h1, rx_h2);
  // A start needs a genuine high-to-low transition, never a low level.
  assign fall = vld_h1 & rx_h1 & ~rx_s;

  // Frame FSM, pending result and output handshake
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend_perr, pend_ferr;
  logic                 done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      pend_perr     <= 1'b0;
      pend_ferr     <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.overrun <= 1'b0;
      done       <= 1'b0;

      // done marks the edge after the last stop sample. A simultaneous
      // accept frees the slot, so the new word replaces the old one.
      if (done) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data    <= shreg;
          rx.parity_err <= pend_perr;
          rx.frame_err  <= pend_ferr;
          rx.rx_valid   <= 1'b1;
        end else begin
          rx.overrun    <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (vote) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= DATA;
              bit_cnt   <= '0;
              pend_perr <= 1'b0;
              pend_ferr <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (vote != ((^shreg) ^ PAR_ODD)) pend_perr <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (!vote) pend_ferr <= 1'b1;
            // Leave at mid-stop-bit so a back-to-back start edge is caught.
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8-bit, 16x-oversampled serial receiver. It keeps the same clk-as-oversample-tick model. New over the previous generation:
- configurable data width, oversample ratio, parity mode and stop-bit count
- input synchroniser, false-start rejection and 3-sample majority vote
- separate parity and framing error flags
- ready/valid output handshake with overrun detection

It sits between the serial pin and the byte-consuming logic, such as a FIFO or command decoder.

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, received LSB first
OVERSAMPLE, 16, clk cycles per bit period, even, >=8
PARITY_EN, 1, 1 = parity bit follows data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  in  1  oversample clock, rising-edge active
rst_n  in  1  synchronous active-low reset
data_in  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, valid while rx_valid=1
rx_valid  out  1  word available; held until accepted
rx_ready  in  1  consumer accepts word on a clk edge where rx_valid & rx_ready
parity_err  out  1  qualifies rx_data; parity mismatch
frame_err  out  1  qualifies rx_data; a stop bit sampled low
overrun  out  1  one-cycle pulse: frame completed while the previous word was still unaccepted
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, all of the following clear to 0 and state goes to IDLE, regardless of frame progress: rx_data, rx_valid, parity_err, frame_err, overrun, busy, counters and the shift register.
- The synchroniser resets to 1, so a line held low through reset is not a start bit.
- data_in passes through a 2-flop synchroniser; rx_s is the synchroniser output. All decisions use rx_s.
- Majority vote: the bit value is the majority of rx_s in the 3 consecutive cycles ending at the sample point.
- IDLE: when rx_s=0, go to START with the cycle counter cleared.
- START: sample point is OVERSAMPLE/2 cycles after entry.
  - Voted 1 -> false start; return to IDLE with no outputs changed.
  - Voted 0 -> go to DATA.
- DATA: sample points every OVERSAMPLE cycles after the start sample.
  - Shift in LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: one sample.
  - Expected bit = XOR of data bits, XOR PARITY_ODD.
  - Mismatch latches a pending parity error.
- STOP: STOP_BITS samples. Any voted 0 latches a pending framing error.
- After the last stop sample, return to IDLE immediately, i.e. at mid-stop-bit, to allow back-to-back frames.
- Delivery, on the clk edge after the final stop sample:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that same cycle: load rx_data, parity_err and frame_err from the pending values, and set rx_valid=1.
  - Otherwise: the new frame is discarded, the old word and flags are kept, and overrun=1 for exactly that cycle.
- Errored frames are still delivered, with their flags set.
- Acceptance: on a clk edge with rx_valid & rx_ready and no simultaneous delivery, rx_valid clears to 0. rx_data and the flags hold their last values; they are don't-care when rx_valid=0.
- Latency: the data_in falling edge to rx_valid=1 is 3 + OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS + PARITY_EN + STOP_BITS) cycles, ±OVERSAMPLE/8 for edge phase.
  - Default parameters: 3 + 8 + 16*10 = 171 cycles.
- A line held low (break) yields a frame with rx_data=0 and frame_err=1.
- While the line stays low, the receiver remains in IDLE until rx_s returns high and falls again; a new frame is never started on a level.

Test Plan:
1. Defaults, rx_ready=1: send 0xA5, parity 0, stop 1, 16 cycles/bit -> rx_valid high one cycle at ~171 cycles after start edge; rx_data=0xA5, parity_err=0, frame_err=0.
2. Glitch: data_in low for 4 cycles then high -> busy pulses, returns to IDLE at mid-start; no rx_valid, no flag change.
3. Errors: send 0x3C with parity bit 1 -> rx_valid, parity_err=1. Then send 0x55 with stop bit 0 -> rx_valid, frame_err=1, parity_err=0.
4. Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, one-cycle overrun pulse at second frame end. Then rx_ready=1 for one cycle -> rx_valid falls.
5. Reset mid-frame: assert rst_n=0 during data bit 4 of 0xF0 for 2 cycles -> all outputs 0 and busy=0 next edge. Next full frame 0x0F is received correctly.
6. Variant DATA_BITS=7, PARITY_ODD=1, STOP_BITS=2, OVERSAMPLE=8: send 0x41 with parity 1 and two stop bits -> rx_data=0x41, no errors. Repeat with second stop bit 0 -> frame_err=1.
